// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : packet widths, field offsets and wakeup/kill helpers shared
//            by rename, dispatch buffer and issue queue.  Rev 1.0
// ============================================================================
package core_pkg;

    localparam int WIDTH_OPC = 7;
    localparam int WIDTH_REG = 5;
    localparam int WIDTH_TAG = 5;
    localparam int WIDTH_BRM = 3;
    localparam int WIDTH_PRY = 2;
    localparam int N_BR      = 1 << WIDTH_BRM;
    localparam int WIDTH_I   = WIDTH_OPC + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + WIDTH_PRY + 3;

    // LSB-first layout; the top bit is a spare carried unchanged
    localparam int POS_PRY  = 0;
    localparam int POS_RDY2 = POS_PRY + WIDTH_PRY;
    localparam int POS_RDY1 = POS_RDY2 + 1;
    localparam int POS_RS2  = POS_RDY1 + 1;
    localparam int POS_RS1  = POS_RS2 + WIDTH_REG;
    localparam int POS_RD   = POS_RS1 + WIDTH_REG;
    localparam int POS_TAG  = POS_RD + WIDTH_REG;
    localparam int POS_BRM  = POS_TAG + WIDTH_TAG;
    localparam int POS_OPC  = POS_BRM + WIDTH_BRM;
    localparam int POS_SPR  = POS_OPC + WIDTH_OPC;

    function automatic logic [WIDTH_I-1:0] wake_pkt(
        input logic [WIDTH_I-1:0]     pkt,
        input logic [4*WIDTH_REG-1:0] wdest
    );
        logic [WIDTH_I-1:0] w_res;
        w_res = pkt;
        for (int i = 0; i < 4; i++) begin
            if (pkt[POS_RS1 +: WIDTH_REG] == wdest[i*WIDTH_REG +: WIDTH_REG])
                w_res[POS_RDY1] = 1'b1;
            if (pkt[POS_RS2 +: WIDTH_REG] == wdest[i*WIDTH_REG +: WIDTH_REG])
                w_res[POS_RDY2] = 1'b1;
        end
        return w_res;
    endfunction

    function automatic logic is_killed(
        input logic [WIDTH_I-1:0] pkt,
        input logic [N_BR-1:0]    brkill
    );
        return brkill[pkt[POS_BRM +: WIDTH_BRM]];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_buffer_if.sv
`default_nettype none
// ============================================================================
// dispatch_buffer_if : rename-side enqueue and issue-side dequeue bundle.
//                      Rev 1.0
// ============================================================================
interface dispatch_buffer_if;
    import core_pkg::*;

    logic [WIDTH_I-1:0] i_inst1;
    logic [WIDTH_I-1:0] i_inst2;
    logic [WIDTH_I-1:0] i_inst3;
    logic [WIDTH_I-1:0] i_inst4;
    logic [3:0]         i_valid;
    logic               o_ready;
    logic [WIDTH_I-1:0] o_inst1;
    logic [WIDTH_I-1:0] o_inst2;
    logic [WIDTH_I-1:0] o_inst3;
    logic [WIDTH_I-1:0] o_inst4;
    logic [3:0]         o_valid;
    logic               i_accept;

    modport slave (
        input  i_inst1, i_inst2, i_inst3, i_inst4, i_valid, i_accept,
        output o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_valid
    );

    modport master (
        output i_inst1, i_inst2, i_inst3, i_inst4, i_valid, i_accept,
        input  o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_valid
    );

endinterface
`default_nettype wire

// File: rtl/dispatch_entry.sv
`default_nettype none
// ============================================================================
// dispatch_entry : one buffered packet plus live bit, kept current with
//                  writeback wakeups and branch kills.  Rev 1.0
// ============================================================================
module dispatch_entry
    import core_pkg::*;
(
    input  wire logic                   i_clk,
    input  wire logic                   i_rst,
    input  wire logic                   i_flush,
    input  wire logic                   i_we,
    input  wire logic [WIDTH_I-1:0]     i_wdata,
    input  wire logic                   i_clr,
    input  wire logic [4*WIDTH_REG-1:0] i_wdest4x,
    input  wire logic [N_BR-1:0]        i_brkill,
    output      logic [WIDTH_I-1:0]     o_pkt,
    output      logic                   o_live
);

    logic [WIDTH_I-1:0] r_pkt;
    logic               r_live;
    logic [WIDTH_I-1:0] w_src;
    logic [WIDTH_I-1:0] w_woke;
    logic               w_kill;

    // Incoming data gets the same wakeup/kill treatment as resident data
    assign w_src  = i_we ? i_wdata : r_pkt;
    assign w_woke = wake_pkt(w_src, i_wdest4x);
    assign w_kill = is_killed(w_src, i_brkill);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pkt  <= '0;
            r_live <= 1'b0;
        end else begin
            r_pkt <= w_woke;
            if (i_flush)
                r_live <= 1'b0;
            else if (i_we)
                r_live <= ~w_kill;
            else if (i_clr || w_kill)
                r_live <= 1'b0;
        end
    end

    assign o_pkt  = r_pkt;
    assign o_live = r_live;

endmodule
`default_nettype wire

// File: rtl/dispatch_buffer.sv
`default_nettype none
// ============================================================================
// dispatch_buffer : circular FIFO between rename and the issue queue,
//                   4 in / 4 presented per cycle.  Rev 1.0
// ============================================================================
module dispatch_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  wire logic                   i_clk,
    input  wire logic                   i_rst,
    input  wire logic                   i_flush,
    dispatch_buffer_if.slave            io_db,
    input  wire logic [4*WIDTH_REG-1:0] i_wdest4x,
    input  wire logic [N_BR-1:0]        i_brkill
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  c_DEPTH = (AW+1)'(DEPTH);

    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [AW:0]        r_count;

    logic [AW:0]        w_free;
    logic               w_ready;
    logic               w_enq;
    logic [2:0]         w_k;
    logic [2:0]         w_kn;
    logic [2:0]         w_d;
    logic [AW:0]        w_kx;
    logic [AW:0]        w_dx;
    logic [WIDTH_I-1:0] w_pkt  [DEPTH];
    logic [DEPTH-1:0]   w_live;
    logic [WIDTH_I-1:0] w_out  [4];
    logic [3:0]         w_oval;

    // Ready looks only at registered occupancy, never at this cycle's dequeue
    assign w_free  = c_DEPTH - r_count;
    assign w_ready = (w_free >= (AW+1)'(4));
    assign w_enq   = io_db.i_valid[0] & w_ready & ~i_flush;
    assign w_k     = {2'b00, io_db.i_valid[0]} + {2'b00, io_db.i_valid[1]}
                   + {2'b00, io_db.i_valid[2]} + {2'b00, io_db.i_valid[3]};
    assign w_kn    = w_enq ? w_k : 3'd0;
    assign w_d     = !io_db.i_accept ? 3'd0 :
                     (r_count >= (AW+1)'(4)) ? 3'd4 : r_count[2:0];
    assign w_kx    = {{(AW-2){1'b0}}, w_kn};
    assign w_dx    = {{(AW-2){1'b0}}, w_d};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_d);
            r_tail  <= r_tail + AW'(w_kn);
            r_count <= r_count + w_kx - w_dx;
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        logic [AW-1:0]      w_toff;
        logic [AW-1:0]      w_hoff;
        logic               w_we;
        logic               w_clr;
        logic [WIDTH_I-1:0] w_wdata;

        assign w_toff = AW'(e) - r_tail;
        assign w_hoff = AW'(e) - r_head;
        assign w_we   = ({1'b0, w_toff} < w_kx);
        assign w_clr  = ({1'b0, w_hoff} < w_dx);

        always_comb begin
            w_wdata = io_db.i_inst1;
            case (w_toff[1:0])
                2'd0:    w_wdata = io_db.i_inst1;
                2'd1:    w_wdata = io_db.i_inst2;
                2'd2:    w_wdata = io_db.i_inst3;
                default: w_wdata = io_db.i_inst4;
            endcase
        end

        dispatch_entry u_entry (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_flush   (i_flush),
            .i_we      (w_we),
            .i_wdata   (w_wdata),
            .i_clr     (w_clr),
            .i_wdest4x (i_wdest4x),
            .i_brkill  (i_brkill),
            .o_pkt     (w_pkt[e]),
            .o_live    (w_live[e])
        );
    end

    for (genvar s = 0; s < 4; s++) begin : g_slot
        logic [AW-1:0] w_idx;
        assign w_idx     = r_head + AW'(s);
        assign w_out[s]  = w_pkt[w_idx];
        assign w_oval[s] = (r_count > (AW+1)'(s)) & w_live[w_idx];
    end

    assign io_db.o_ready = w_ready;
    assign io_db.o_valid = w_oval;
    assign io_db.o_inst1 = w_out[0];
    assign io_db.o_inst2 = w_out[1];
    assign io_db.o_inst3 = w_out[2];
    assign io_db.o_inst4 = w_out[3];

endmodule
`default_nettype wire
